// File: rtl/dma_mem_engine.sv
// DMA responder for the rsa coprocessor: moves one BLOCK_W-bit block per request
// between memory and the coprocessor over a single-outstanding BUS_W-bit port.
module dma_mem_engine #(
  parameter int BLOCK_W = 1024,
  parameter int BUS_W   = 32,
  parameter int TIMEOUT = 1024
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               dma_rx_start,
  input  logic [31:0]        dma_rx_address,
  input  logic               dma_tx_start,
  input  logic [31:0]        dma_tx_address,
  input  logic [BLOCK_W-1:0] dma_tx_data,
  output logic [BLOCK_W-1:0] dma_rx_data,
  output logic               dma_done,
  output logic               dma_idle,
  output logic               dma_error,
  output logic               mem_req,
  output logic               mem_we,
  output logic [31:0]        mem_addr,
  output logic [BUS_W-1:0]   mem_wdata,
  input  logic               mem_gnt,
  input  logic               mem_rvalid,
  input  logic [BUS_W-1:0]   mem_rdata,
  input  logic               mem_err
);

  localparam int BEATS  = BLOCK_W / BUS_W;
  localparam int BEAT_W = $clog2(BEATS);
  localparam int BYTES  = BUS_W / 8;
  localparam int TMO_W  = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    IDLE,
    RD_REQ,
    RD_DATA,
    WR_REQ,
    FIN
  } state_t;

  state_t             state, state_next;
  logic [31:0]        base_addr;
  logic [BEAT_W-1:0]  beat;
  logic [TMO_W-1:0]   tmo_cnt;
  logic [BLOCK_W-1:0] txbuf;

  logic        accept_rx;
  logic        accept_tx;
  logic        err_set;
  logic        beat_inc;
  logic        progress;
  logic        rx_we;
  logic        last_beat;
  logic        tmo_hit;
  logic        waiting;
  logic [31:0] cur_addr;

  assign last_beat = (beat == BEAT_W'(BEATS - 1));
  assign tmo_hit   = (tmo_cnt == TMO_W'(TIMEOUT - 1));
  assign waiting   = (state == RD_REQ) || (state == RD_DATA) || (state == WR_REQ);
  // Modulo-2^32 sum: a block that runs past 0xFFFFFFFC simply wraps.
  assign cur_addr  = base_addr + (32'(beat) * 32'(BYTES));

  assign dma_done = (state == FIN);
  assign dma_idle = (state == IDLE);

  // NOTE: every signal driven here gets a default first, so no path leaves one
  // unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    accept_rx  = 1'b0;
    accept_tx  = 1'b0;
    err_set    = 1'b0;
    beat_inc   = 1'b0;
    progress   = 1'b0;
    rx_we      = 1'b0;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;

    case (state)
      IDLE: begin
        // rx has priority; a simultaneous tx request is dropped.
        if (dma_rx_start) begin
          accept_rx = 1'b1;
          if (dma_rx_address[1:0] != 2'b00) begin
            err_set    = 1'b1;
            state_next = FIN;
          end else begin
            state_next = RD_REQ;
          end
        end else if (dma_tx_start) begin
          accept_tx = 1'b1;
          if (dma_tx_address[1:0] != 2'b00) begin
            err_set    = 1'b1;
            state_next = FIN;
          end else begin
            state_next = WR_REQ;
          end
        end
      end

      RD_REQ: begin
        mem_req  = 1'b1;
        mem_addr = cur_addr;
        if (mem_gnt) begin
          progress   = 1'b1;
          state_next = RD_DATA;
        end else if (tmo_hit) begin
          err_set    = 1'b1;
          state_next = FIN;
        end
      end

      RD_DATA: begin
        if (mem_rvalid) begin
          progress = 1'b1;
          if (mem_err) begin
            // The erroring word is discarded; earlier lanes keep their new data.
            err_set    = 1'b1;
            state_next = FIN;
          end else begin
            rx_we = 1'b1;
            if (last_beat) begin
              state_next = FIN;
            end else begin
              beat_inc   = 1'b1;
              state_next = RD_REQ;
            end
          end
        end else if (tmo_hit) begin
          err_set    = 1'b1;
          state_next = FIN;
        end
      end

      WR_REQ: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = cur_addr;
        mem_wdata = txbuf[int'(beat)*BUS_W +: BUS_W];
        if (mem_gnt) begin
          progress = 1'b1;
          if (mem_err) begin
            err_set    = 1'b1;
            state_next = FIN;
          end else if (last_beat) begin
            state_next = FIN;
          end else begin
            beat_inc = 1'b1;
          end
        end else if (tmo_hit) begin
          err_set    = 1'b1;
          state_next = FIN;
        end
      end

      FIN: begin
        state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      base_addr   <= '0;
      beat        <= '0;
      tmo_cnt     <= '0;
      dma_error   <= 1'b0;
      dma_rx_data <= '0;
    end else begin
      state <= state_next;
      if (accept_rx || accept_tx) begin
        base_addr <= accept_rx ? dma_rx_address : dma_tx_address;
        beat      <= '0;
        tmo_cnt   <= '0;
        dma_error <= err_set;
      end else begin
        if (err_set) begin
          dma_error <= 1'b1;
        end
        if (beat_inc) begin
          beat <= beat + 1'b1;
        end
        if (progress) begin
          tmo_cnt <= '0;
        end else if (waiting) begin
          tmo_cnt <= tmo_cnt + 1'b1;
        end
        if (rx_we) begin
          dma_rx_data[int'(beat)*BUS_W +: BUS_W] <= mem_rdata;
        end
      end
    end
  end

  // NOTE: the tx buffer is a plain data store, loaded on every write accept
  // before it is read, so it carries no reset.
  always_ff @(posedge clk) begin
    if (accept_tx) begin
      txbuf <= dma_tx_data;
    end
  end

endmodule

// File: tb/tb_dma_mem_engine.sv
// Directed self-checking bench for dma_mem_engine with a zero-wait memory
// responder that can withhold grants or flag an error on a chosen read beat.
module tb_dma_mem_engine;

  logic          clk = 1'b0;
  logic          reset;
  logic          dma_rx_start;
  logic [31:0]   dma_rx_address;
  logic          dma_tx_start;
  logic [31:0]   dma_tx_address;
  logic [1023:0] dma_tx_data;
  logic [1023:0] dma_rx_data;
  logic          dma_done;
  logic          dma_idle;
  logic          dma_error;
  logic          mem_req;
  logic          mem_we;
  logic [31:0]   mem_addr;
  logic [31:0]   mem_wdata;
  logic          mem_gnt;
  logic          mem_rvalid;
  logic [31:0]   mem_rdata;
  logic          mem_err;

  int checks   = 0;
  int failures = 0;

  dma_mem_engine #(.BLOCK_W(1024), .BUS_W(32), .TIMEOUT(16)) dut (
    .clk            (clk),
    .reset          (reset),
    .dma_rx_start   (dma_rx_start),
    .dma_rx_address (dma_rx_address),
    .dma_tx_start   (dma_tx_start),
    .dma_tx_address (dma_tx_address),
    .dma_tx_data    (dma_tx_data),
    .dma_rx_data    (dma_rx_data),
    .dma_done       (dma_done),
    .dma_idle       (dma_idle),
    .dma_error      (dma_error),
    .mem_req        (mem_req),
    .mem_we         (mem_we),
    .mem_addr       (mem_addr),
    .mem_wdata      (mem_wdata),
    .mem_gnt        (mem_gnt),
    .mem_rvalid     (mem_rvalid),
    .mem_rdata      (mem_rdata),
    .mem_err        (mem_err)
  );

  always #5 clk = ~clk;

  // Memory responder and event monitor.
  logic        gnt_en;
  logic        log_clr;
  int          err_beat;
  logic        rvalid_q;
  logic        rerr_q;
  logic [31:0] rdata_q;
  logic [31:0] mem [0:4095];
  logic [31:0] addr_log [0:63];
  int          log_n;
  int          rd_cnt;
  int          wr_cnt;
  int          done_cnt;
  int          req_cnt;

  // Read data pattern: word i of the block at 0x1000 is 0xA5000000 + i.
  function automatic logic [31:0] gen_word(input logic [31:0] a);
    return 32'hA500_0000 + ((a - 32'h0000_1000) >> 2);
  endfunction

  assign mem_gnt    = mem_req & gnt_en;
  assign mem_rvalid = rvalid_q;
  assign mem_rdata  = rdata_q;
  assign mem_err    = rvalid_q & rerr_q;

  always @(posedge clk) begin
    if (log_clr) begin
      rvalid_q <= 1'b0;
      rerr_q   <= 1'b0;
      rdata_q  <= '0;
      log_n    <= 0;
      rd_cnt   <= 0;
      wr_cnt   <= 0;
      done_cnt <= 0;
      req_cnt  <= 0;
    end else begin
      rvalid_q <= 1'b0;
      rerr_q   <= 1'b0;
      if (mem_req) req_cnt <= req_cnt + 1;
      if (dma_done) done_cnt <= done_cnt + 1;
      if (mem_req && mem_gnt) begin
        if (log_n < 64) addr_log[log_n] <= mem_addr;
        log_n <= log_n + 1;
        if (mem_we) begin
          mem[mem_addr[13:2]] <= mem_wdata;
          wr_cnt <= wr_cnt + 1;
        end else begin
          rvalid_q <= 1'b1;
          rdata_q  <= gen_word(mem_addr);
          rerr_q   <= (rd_cnt == err_beat);
          rd_cnt   <= rd_cnt + 1;
        end
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic clear_log();
    @(negedge clk);
    log_clr = 1'b1;
    @(negedge clk);
    log_clr = 1'b0;
  endtask

  // Issue a request at a negedge, hold the starts for `hold` cycles after the
  // accept edge, and count negedges from the accept edge until dma_done.
  task automatic go(input logic rx, input logic tx, input logic [31:0] ra,
                    input logic [31:0] ta, input int hold, output int lat);
    clear_log();
    dma_rx_start   = rx;
    dma_tx_start   = tx;
    dma_rx_address = ra;
    dma_tx_address = ta;
    @(posedge clk);
    lat = 0;
    while (lat < 300) begin
      @(negedge clk);
      lat++;
      if (lat == 1) dma_tx_data = '0;
      if (lat == hold) begin
        dma_rx_start = 1'b0;
        dma_tx_start = 1'b0;
      end
      if (dma_done) break;
    end
    dma_rx_start = 1'b0;
    dma_tx_start = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    int lat;
    int n;
    reset          = 1'b1;
    dma_rx_start   = 1'b0;
    dma_tx_start   = 1'b0;
    dma_rx_address = '0;
    dma_tx_address = '0;
    dma_tx_data    = '0;
    gnt_en         = 1'b1;
    log_clr        = 1'b1;
    err_beat       = -1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_idle",  dma_idle, 1);
    check("rst_done",  dma_done, 0);
    check("rst_err",   dma_error, 0);
    check("rst_req",   mem_req, 0);
    check("rst_we",    mem_we, 0);
    check("rst_addr",  mem_addr, 0);
    check("rst_wdata", mem_wdata, 0);
    check("rst_rx0",   dma_rx_data[63:0], 0);
    reset   = 1'b0;
    log_clr = 1'b0;

    // Zero-wait read of the block at 0x1000.
    go(1'b1, 1'b0, 32'h0000_1000, 32'h0, 1, lat);
    check("rd_lat",    lat, 65);
    check("rd_err",    dma_error, 0);
    check("rd_lane0",  dma_rx_data[31:0], 32'hA500_0000);
    check("rd_lane31", dma_rx_data[1023:992], 32'hA500_001F);
    check("rd_addr0",  addr_log[0], 32'h0000_1000);
    check("rd_addr31", addr_log[31], 32'h0000_107C);
    check("rd_count",  rd_cnt, 32);
    check("rd_pulses", done_cnt, 1);
    check("rd_idle",   dma_idle, 1);

    // Read at 0x1400 with a bus error on beat 7.
    err_beat = 7;
    go(1'b1, 1'b0, 32'h0000_1400, 32'h0, 1, lat);
    err_beat = -1;
    check("rderr_lat",    lat, 17);
    check("rderr_err",    dma_error, 1);
    check("rderr_lane0",  dma_rx_data[31:0], 32'hA500_0100);
    check("rderr_lane6",  dma_rx_data[223:192], 32'hA500_0106);
    check("rderr_lane7",  dma_rx_data[255:224], 32'hA500_0007);
    check("rderr_lane31", dma_rx_data[1023:992], 32'hA500_001F);
    repeat (4) @(negedge clk);
    check("rderr_sticky", dma_error, 1);
    check("rderr_pulses", done_cnt, 1);

    // Write: word i = i; tx data is zeroed right after accept.
    for (int i = 0; i < 32; i++) dma_tx_data[32*i +: 32] = 32'(i);
    go(1'b0, 1'b1, 32'h0, 32'h0000_2000, 1, lat);
    check("wr_lat",    lat, 33);
    check("wr_err",    dma_error, 0);
    check("wr_count",  wr_cnt, 32);
    check("wr_mem0",   mem[12'h800], 32'h0);
    check("wr_mem15",  mem[12'h80F], 32'hF);
    check("wr_mem31",  mem[12'h81F], 32'h1F);
    check("wr_addr31", addr_log[31], 32'h0000_207C);

    // Simultaneous starts, both held 5 cycles: one read only.
    for (int i = 0; i < 32; i++) dma_tx_data[32*i +: 32] = 32'hDEAD_0000 + 32'(i);
    go(1'b1, 1'b1, 32'h0000_1000, 32'h0000_2400, 5, lat);
    repeat (3) @(negedge clk);
    check("sim_lat",    lat, 65);
    check("sim_reads",  rd_cnt, 32);
    check("sim_writes", wr_cnt, 0);
    check("sim_pulses", done_cnt, 1);

    // Grant withheld: timeout after 16 waiting cycles.
    gnt_en = 1'b0;
    go(1'b1, 1'b0, 32'h0000_3000, 32'h0, 1, lat);
    gnt_en = 1'b1;
    check("tmo_lat",   lat, 17);
    check("tmo_err",   dma_error, 1);
    check("tmo_reads", rd_cnt, 0);

    // Misaligned read address.
    go(1'b1, 1'b0, 32'h0000_1002, 32'h0, 1, lat);
    check("mis_lat", lat, 1);
    check("mis_err", dma_error, 1);
    check("mis_req", req_cnt, 0);

    // Block wrapping past the top of the address space.
    go(1'b1, 1'b0, 32'hFFFF_FFC0, 32'h0, 1, lat);
    check("wrap_lat",  lat, 65);
    check("wrap_err",  dma_error, 0);
    check("wrap_a15",  addr_log[15], 32'hFFFF_FFFC);
    check("wrap_a16",  addr_log[16], 32'h0000_0000);

    // Reset during beat 10 of a write.
    clear_log();
    dma_tx_address = 32'h0000_2800;
    dma_tx_start   = 1'b1;
    @(negedge clk);
    dma_tx_start = 1'b0;
    n = 0;
    while (wr_cnt < 10 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("rstw_reach10", (wr_cnt == 10) ? 1 : 0, 1);
    reset = 1'b1;
    @(negedge clk);
    check("rstw_req",  mem_req, 0);
    check("rstw_idle", dma_idle, 1);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check("rstw_nodone", done_cnt, 0);

    // Normal read after the aborted write.
    go(1'b1, 1'b0, 32'h0000_1000, 32'h0, 1, lat);
    check("post_lat",   lat, 65);
    check("post_err",   dma_error, 0);
    check("post_lane5", dma_rx_data[191:160], 32'hA500_0005);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
